display_seq: RTL and testbench

Sequential, parametrised binary-to-7-segment display driver. Converts a WIDTH-bit value to DIGITS decimal digits using iterative double-dabble, one bit per clock. Adds signed mode, leading-zero blanking, overflow indication and a start/done handshake. Sits between the calculator result register and the HEX display outputs.

---
 rtl/display_pkg.sv | 22 ++
 rtl/display_seq_dabble_step.sv | 19 +
 rtl/display_seq.sv | 93 +++++++++
 tb/tb_display_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared FSM states and 7-segment encoding for display_seq
// Segment codes are active-low {dp,g,f,e,d,c,b,a}; dp is always off.
package display_pkg;
  typedef enum logic [1:0] {IDLE, CONVERT, RENDER} state_t;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  function automatic logic [7:0] digit_to_seg(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/display_seq_dabble_step.sv
// dabble_step: one double-dabble iteration (add-3 correction, then shift in one bit)
// Ports: bcd = current BCD register, bit_in = next binary bit (MSB first),
//        bcd_next = corrected and shifted BCD, carry = bit shifted out of the top digit.
module dabble_step #(
  parameter int DIGITS = 6
) (
  input  logic [4*DIGITS-1:0] bcd,
  input  logic                bit_in,
  output logic [4*DIGITS-1:0] bcd_next,
  output logic                carry
);
  logic [4*DIGITS-1:0] corr;
  always_comb begin
    corr = '0;
    for (int i = 0; i < DIGITS; i++)
      corr[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
  end
  assign {carry, bcd_next} = {corr, bit_in};
endmodule

// File: rtl/display_seq.sv
// display_seq: sequential binary-to-7-segment driver using double-dabble, one bit per clock
// Ports: clk/rst (sync, active-high); start/num/is_signed/blank_lz request a conversion in IDLE;
//        busy spans conversion, done pulses one cycle when segments/overflow are updated;
//        segments holds DIGITS active-low codes, digit 0 in the low byte.
module display_seq
  import display_pkg::*;
#(
  parameter int WIDTH  = 21,
  parameter int DIGITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    num,
  input  logic                is_signed,
  input  logic                blank_lz,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [8*DIGITS-1:0] segments
);
  localparam int CW = $clog2(WIDTH);
  state_t              state;
  logic [WIDTH-1:0]    mag;
  logic [4*DIGITS-1:0] bcd, bcd_next;
  logic [CW-1:0]       cnt;
  logic                sticky, neg, blz, carry, ovf_n;
  logic [8*DIGITS-1:0] seg_n;
  int                  msd;
  dabble_step #(.DIGITS(DIGITS)) u_step (
    .bcd      (bcd),
    .bit_in   (mag[WIDTH-1]),
    .bcd_next (bcd_next),
    .carry    (carry)
  );
  // msd is the most significant nonzero digit, 0 when the value is zero so digit 0 always shows.
  // A negative value needs one free position for the minus sign, hence the top-digit check.
  always_comb begin
    msd = 0;
    for (int i = 1; i < DIGITS; i++)
      if (bcd[4*i+:4] != 4'd0) msd = i;
    ovf_n = sticky | (neg & (bcd[4*DIGITS-1-:4] != 4'd0));
    seg_n = '1;
    for (int i = 0; i < DIGITS; i++)
      seg_n[8*i+:8] = ovf_n ? SEG_MINUS :
                      (neg && i == (blz ? msd + 1 : DIGITS - 1)) ? SEG_MINUS :
                      (!blz || i <= msd) ? digit_to_seg(bcd[4*i+:4]) : SEG_BLANK;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      segments <= {DIGITS{SEG_BLANK}};
      mag      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      sticky   <= 1'b0;
      neg      <= 1'b0;
      blz      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          neg    <= is_signed & num[WIDTH-1];
          mag    <= (is_signed & num[WIDTH-1]) ? -num : num;
          blz    <= blank_lz;
          bcd    <= '0;
          sticky <= 1'b0;
          cnt    <= CW'(WIDTH - 1);
          busy   <= 1'b1;
          state  <= CONVERT;
        end
        CONVERT: begin
          bcd    <= bcd_next;
          mag    <= mag << 1;
          sticky <= sticky | carry;
          cnt    <= cnt - 1'b1;
          state  <= cnt == '0 ? RENDER : CONVERT;
        end
        RENDER: begin
          segments <= seg_n;
          overflow <= ovf_n;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_display_seq.sv
// tb_display_seq: self-checking bench for display_seq (vector table, random vs. model, handshake corners)
module tb_display_seq;
  logic        clk = 0, rst = 1, start = 0, is_signed = 0, blank_lz = 0;
  logic [20:0] num = '0;
  logic        busy, done, overflow;
  logic [47:0] segments;
  int          errors = 0, checks = 0;
  logic [7:0]  codes [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  typedef struct {
    logic [20:0] n;
    logic        s, b;
    logic [47:0] seg;
    logic        ovf;
  } vec_t;
  vec_t vt [12];

  display_seq #(.WIDTH(21), .DIGITS(6)) dut (
    .clk(clk), .rst(rst), .start(start), .num(num), .is_signed(is_signed),
    .blank_lz(blank_lz), .busy(busy), .done(done), .overflow(overflow), .segments(segments)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: decimal digits from integer division, sign/overflow from magnitude ranges.
  function automatic void model(input logic [20:0] n, input logic s, input logic b,
                                output logic [47:0] seg, output logic ovf);
    longint mag, pw;
    int     len;
    logic   neg;
    neg = s && n[20];
    mag = neg ? (longint'(1) << 21) - longint'(n) : longint'(n);
    len = 1;
    for (longint p = 10; p <= mag; p *= 10) len++;
    ovf = (mag >= 1000000) || (neg && mag >= 100000);
    seg = '1;
    pw = 1;
    for (int i = 0; i < 6; i++) begin
      seg[8*i+:8] = ovf ? 8'hBF : (!b || i < len) ? codes[int'((mag / pw) % 10)] : 8'hFF;
      pw *= 10;
    end
    if (!ovf && neg) seg[8*(b ? len : 5)+:8] = 8'hBF;
  endfunction

  // Call just after a negedge; returns just after the accepting posedge.
  task automatic do_start(input logic [20:0] n, input logic s, input logic b);
    start = 1; num = n; is_signed = s; blank_lz = b;
    @(posedge clk);
    #1 start = 0;
  endtask

  // k counts cycles after the accept cycle; returns at the negedge where done is seen.
  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (k <= 40) begin
      @(negedge clk);
      if (done) return;
      k++;
    end
  endtask

  task automatic convert_check(input string name, input logic [20:0] n, input logic s,
                               input logic b, input logic [47:0] eseg, input logic eovf);
    int k;
    do_start(n, s, b);
    wait_done(1, k);
    check({name, "_latency"}, 48'(k), 48'd23);
    check({name, "_seg"}, segments, eseg);
    check({name, "_ovf"}, 48'(overflow), 48'(eovf));
    check({name, "_busy_at_done"}, 48'(busy), 48'd0);
  endtask

  initial begin
    int k, nd;
    logic [47:0] mseg;
    logic        movf;
    logic [20:0] rn;
    logic        rs, rb;
    vt[0]  = '{21'd123456,  1'b0, 1'b0, 48'hF9A4B0999282, 1'b0};
    vt[1]  = '{21'd42,      1'b0, 1'b1, 48'hFFFFFFFF99A4, 1'b0};
    vt[2]  = '{21'd0,       1'b0, 1'b1, 48'hFFFFFFFFFFC0, 1'b0};
    vt[3]  = '{21'd0,       1'b0, 1'b0, 48'hC0C0C0C0C0C0, 1'b0};
    vt[4]  = '{21'h1FFFD6,  1'b1, 1'b1, 48'hFFFFFFBF99A4, 1'b0};
    vt[5]  = '{21'h1FFFD6,  1'b1, 1'b0, 48'hBFC0C0C099A4, 1'b0};
    vt[6]  = '{21'd1000000, 1'b0, 1'b0, 48'hBFBFBFBFBFBF, 1'b1};
    vt[7]  = '{21'h1E7960,  1'b1, 1'b1, 48'hBFBFBFBFBFBF, 1'b1};
    vt[8]  = '{21'h1E7961,  1'b1, 1'b0, 48'hBF9090909090, 1'b0};
    vt[9]  = '{21'd999999,  1'b0, 1'b1, 48'h909090909090, 1'b0};
    vt[10] = '{21'h100000,  1'b1, 1'b0, 48'hBFBFBFBFBFBF, 1'b1};
    vt[11] = '{21'd42,      1'b1, 1'b0, 48'hC0C0C0C099A4, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_seg", segments, 48'hFFFFFFFFFFFF);
    check("reset_busy", 48'(busy), 48'd0);
    check("reset_done", 48'(done), 48'd0);
    check("reset_ovf", 48'(overflow), 48'd0);
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      convert_check($sformatf("vec%0d", i), vt[i].n, vt[i].s, vt[i].b, vt[i].seg, vt[i].ovf);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 48'(done), 48'd0);
      check($sformatf("vec%0d_hold", i), segments, vt[i].seg);
    end

    for (int i = 0; i < 60; i++) begin
      rn = 21'($urandom);
      if (i % 3 == 0) rn = 21'($urandom_range(0, 999));
      if (i % 5 == 1) rn = 21'(-$urandom_range(1, 120000));
      rs = 1'($urandom); rb = 1'($urandom);
      model(rn, rs, rb, mseg, movf);
      convert_check($sformatf("rnd%0d_%h_%0d%0d", i, rn, rs, rb), rn, rs, rb, mseg, movf);
      @(negedge clk);
    end

    // start during conversion is ignored; the original value is displayed once
    do_start(21'd123456, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    start = 1; num = 21'd42; blank_lz = 1;
    @(negedge clk);
    start = 0;
    wait_done(7, k);
    check("ignore_latency", 48'(k), 48'd23);
    check("ignore_seg", segments, 48'hF9A4B0999282);
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("ignore_no_extra_done", 48'(nd), 48'd0);

    // start in the done cycle is accepted back-to-back
    @(negedge clk);
    do_start(21'd42, 1'b0, 1'b1);
    wait_done(1, k);
    do_start(21'h1FFFD6, 1'b1, 1'b1);
    wait_done(1, k);
    check("b2b_latency", 48'(k), 48'd23);
    check("b2b_seg", segments, 48'hFFFFFFBF99A4);

    // reset mid-conversion aborts with no done pulse
    @(negedge clk);
    do_start(21'd777, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    check("abort_busy_before", 48'(busy), 48'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_seg", segments, 48'hFFFFFFFFFFFF);
    check("abort_busy", 48'(busy), 48'd0);
    check("abort_ovf", 48'(overflow), 48'd0);
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", 48'(nd), 48'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
